// File: rtl/axi_slave_mem.sv
// AXI INCR burst slave over a word memory with per-word user sideband; one burst per path, R beat 0 one cycle after AR.
// Registered outputs; R and B hold stable under backpressure, AW/AR are not accepted until the current burst retires.
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int MEM_DEPTH  = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [7:0]                awlen,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic [USER_WIDTH-1:0]     wuser,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic [USER_WIDTH-1:0]     buser,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [7:0]                arlen,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic [USER_WIDTH-1:0]     ruser,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int STRB = DATA_WIDTH / 8;
  localparam int LSB  = (STRB > 1) ? $clog2(STRB) : 0;
  localparam int IW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [8:0] DEPTH9 = 9'(MEM_DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [DATA_WIDTH-1:0] mem  [MEM_DEPTH];
  logic [USER_WIDTH-1:0] umem [MEM_DEPTH];

  logic [1:0] wstate;
  logic [8:0] widx;
  logic [7:0] wlen, wbeat;
  logic       werr;
  logic [0:0] rstate;
  logic [8:0] ridx;
  logic [7:0] rlen, rbeat;

  logic                  w_hs, w_inr, w_last, w_bad;
  logic [DATA_WIDTH-1:0] w_cur, w_merged;

  assign w_hs   = wvalid && wready;
  assign w_inr  = widx < DEPTH9;
  assign w_last = wbeat == wlen;
  assign w_bad  = !w_inr || (wlast != w_last);

  always_comb begin
    w_cur = '0;
    if (w_inr) w_cur = mem[widx[IW-1:0]];
    for (int b = 0; b < STRB; b++)
      w_merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : w_cur[8*b +: 8];
  end

  // Each word is its own register so reset can clear the whole array without a loop over memory.
  for (genvar i = 0; i < MEM_DEPTH; i++) begin : g_word
    logic [DATA_WIDTH-1:0] word_q;
    logic [USER_WIDTH-1:0] user_q;
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        word_q <= '0;
        user_q <= '0;
      end else if (w_hs && w_inr && widx == 9'(i)) begin
        word_q <= w_merged;
        user_q <= wuser;
      end
    end
    assign mem[i]  = word_q;
    assign umem[i] = user_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wstate  <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      buser   <= '0;
      widx    <= '0;
      wlen    <= '0;
      wbeat   <= '0;
      werr    <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (awvalid && awready) begin
            widx    <= 9'(awaddr >> LSB);
            wlen    <= awlen;
            wbeat   <= '0;
            werr    <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            wstate  <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            widx  <= widx + 9'd1;
            wbeat <= wbeat + 8'd1;
            // Beat count alone ends the burst; a misplaced wlast only flags an error.
            if (w_last) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp  <= (werr || w_bad) ? 2'b10 : 2'b00;
              buser  <= wuser;
              wstate <= W_RESP;
            end else begin
              werr <= werr || w_bad;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            werr    <= 1'b0;
            awready <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  logic [8:0]            rd_idx;
  logic                  rd_inr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [USER_WIDTH-1:0] rd_user;

  // Address of the beat to present next: the burst start while idle, else the following word.
  always_comb begin
    rd_idx  = (rstate == R_IDLE) ? 9'(araddr >> LSB) : ridx + 9'd1;
    rd_inr  = rd_idx < DEPTH9;
    rd_word = '0;
    rd_user = '0;
    if (rd_inr) begin
      rd_word = mem[rd_idx[IW-1:0]];
      rd_user = umem[rd_idx[IW-1:0]];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
      rlast   <= 1'b0;
      ruser   <= '0;
      ridx    <= '0;
      rlen    <= '0;
      rbeat   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (arvalid && arready) begin
            rlen    <= arlen;
            rbeat   <= '0;
            ridx    <= rd_idx;
            rdata   <= rd_word;
            ruser   <= rd_user;
            rresp   <= rd_inr ? 2'b00 : 2'b10;
            rlast   <= arlen == 8'd0;
            rvalid  <= 1'b1;
            arready <= 1'b0;
            rstate  <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              rbeat <= rbeat + 8'd1;
              ridx  <= rd_idx;
              rdata <= rd_word;
              ruser <= rd_user;
              rresp <= rd_inr ? 2'b00 : 2'b10;
              rlast <= (rbeat + 8'd1) == rlen;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: expected B/R results are queued at stimulus time and popped as the DUT responds.
module tb_axi_slave_mem;

  localparam int DEPTH = 32;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [0:0]  wuser = '0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0]  bresp, rresp;
  logic [0:0]  buser, ruser;
  logic [31:0] rdata;

  axi_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .USER_WIDTH(1), .MEM_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed { logic [31:0] data; logic [0:0] user; logic [1:0] resp; logic last; } rexp_t;
  typedef struct packed { logic [1:0] resp; logic [0:0] user; } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] model_mem [DEPTH];
  logic [0:0]  model_user[DEPTH];
  logic [31:0] tb_wd[16];
  logic [3:0]  tb_ws[16];
  logic [0:0]  tb_wu[16];
  int          rstall[16];
  int          passed = 0, total = 0, wstall_cyc = 0;

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr_burst(input logic [7:0] addr, input int len, input int wlast_at, input int bdelay);
    logic [8:0] base;
    logic       err;
    bexp_t      e, got;
    int         n;
    base = 9'(addr >> 2);
    err  = 1'b0;
    for (int k = 0; k <= len; k++) begin
      int idx;
      idx = int'(base) + k;
      if (idx < DEPTH) begin
        for (int b = 0; b < 4; b++)
          if (tb_ws[k][b]) model_mem[idx][8*b +: 8] = tb_wd[k][8*b +: 8];
        model_user[idx] = tb_wu[k];
      end else err = 1'b1;
      if ((k == wlast_at) != (k == len)) err = 1'b1;
    end
    e.resp = err ? 2'b10 : 2'b00;
    e.user = tb_wu[len];
    bq.push_back(e);

    awaddr = addr; awlen = 8'(len); awvalid = 1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin cyc(); n++; end
    total++;
    if (n >= 50) $display("FAIL aw_timeout awready=%b need 1", awready); else passed++;
    cyc();
    awvalid = 0;

    for (int k = 0; k <= len; k++) begin
      wdata = tb_wd[k]; wstrb = tb_ws[k]; wuser = tb_wu[k]; wlast = (k == wlast_at); wvalid = 1;
      n = 0;
      while (wready !== 1'b1 && n < 50) begin cyc(); n++; wstall_cyc++; end
      total++;
      if (n >= 50) $display("FAIL w_timeout beat %0d wready=%b need 1", k, wready); else passed++;
      cyc();
    end
    wvalid = 0; wlast = 0;

    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin cyc(); n++; end
    total++;
    if (n >= 50) $display("FAIL b_timeout bvalid=%b need 1", bvalid); else passed++;
    for (int i = 0; i < bdelay; i++) begin
      total++;
      if ({bvalid, bresp, buser, awready} !== {1'b1, e.resp, e.user, 1'b0})
        $display("FAIL b_stall cyc %0d got v/resp/user/awready=%b/%b/%b/%b need 1/%b/%b/0",
                 i, bvalid, bresp, buser, awready, e.resp, e.user);
      else passed++;
      cyc();
    end
    bready = 1;
    got = bq.pop_front();
    total++;
    if ({bresp, buser} !== {got.resp, got.user})
      $display("FAIL b_resp got resp=%b user=%b need resp=%b user=%b", bresp, buser, got.resp, got.user);
    else passed++;
    cyc();
    bready = 0;
    total++;
    if ({bvalid, awready} !== 2'b01)
      $display("FAIL b_done got bvalid=%b awready=%b need 0/1", bvalid, awready);
    else passed++;
  endtask

  task automatic rd_burst(input logic [7:0] addr, input int len);
    logic [8:0] base;
    rexp_t      e;
    int         n;
    base = 9'(addr >> 2);
    for (int k = 0; k <= len; k++) begin
      int idx;
      idx = int'(base) + k;
      e.data = (idx < DEPTH) ? model_mem[idx] : 32'h0;
      e.user = (idx < DEPTH) ? model_user[idx] : 1'b0;
      e.resp = (idx < DEPTH) ? 2'b00 : 2'b10;
      e.last = (k == len);
      rq.push_back(e);
    end

    araddr = addr; arlen = 8'(len); arvalid = 1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin cyc(); n++; end
    total++;
    if (n >= 50) $display("FAIL ar_timeout arready=%b need 1", arready); else passed++;
    cyc();
    arvalid = 0;
    total++;
    if ({rvalid, arready} !== 2'b10)
      $display("FAIL r_first_cycle got rvalid=%b arready=%b need 1/0", rvalid, arready);
    else passed++;

    for (int k = 0; k <= len; k++) begin
      for (int s = 0; s < rstall[k]; s++) begin
        rready = 0;
        total++;
        if ({rvalid, rdata, ruser, rresp, rlast} !== {1'b1, rq[0]})
          $display("FAIL r_stall beat %0d got %h/%b/%b/%b need %h/%b/%b/%b",
                   k, rdata, ruser, rresp, rlast, rq[0].data, rq[0].user, rq[0].resp, rq[0].last);
        else passed++;
        cyc();
      end
      rready = 1;
      n = 0;
      while (rvalid !== 1'b1 && n < 50) begin cyc(); n++; end
      e = rq.pop_front();
      total++;
      if ({rvalid, rdata, ruser, rresp, rlast} !== {1'b1, e})
        $display("FAIL r_beat %0d got v=%b %h/%b/%b/%b need %h/%b/%b/%b",
                 k, rvalid, rdata, ruser, rresp, rlast, e.data, e.user, e.resp, e.last);
      else passed++;
      cyc();
    end
    rready = 0;
    total++;
    if ({rvalid, arready} !== 2'b01)
      $display("FAIL r_done got rvalid=%b arready=%b need 0/1", rvalid, arready);
    else passed++;
  endtask

  task automatic test_reset();
    aresetn = 0;
    cyc(); cyc();
    total++;
    if ({awready, wready, bvalid, bresp, buser, arready, rvalid, rdata, rresp, rlast, ruser} !== '0)
      $display("FAIL reset_outputs got aw/w/b/ar/r=%b%b%b%b%b need all 0", awready, wready, bvalid, arready, rvalid);
    else passed++;
    aresetn = 1;
    cyc();
    total++;
    if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000)
      $display("FAIL reset_release got aw/ar/w/b/r=%b%b%b%b%b need 11000", awready, arready, wready, bvalid, rvalid);
    else passed++;
  endtask

  task automatic test_single();
    tb_wd[0] = 32'hDEADBEEF; tb_ws[0] = 4'hF; tb_wu[0] = 1'b1;
    wr_burst(8'h08, 0, 0, 0);
    rd_burst(8'h08, 0);
  endtask

  task automatic test_strobe_burst();
    for (int k = 0; k < 4; k++) begin
      tb_wd[k] = 32'h11111111 * (k + 1); tb_ws[k] = 4'hF; tb_wu[k] = 1'(k);
    end
    wr_burst(8'h10, 3, 3, 0);
    tb_wd[0] = 32'hAABBCCDD; tb_ws[0] = 4'h3; tb_wu[0] = 1'b0;
    wr_burst(8'h14, 0, 0, 0);
    rd_burst(8'h10, 3);
  endtask

  task automatic test_backpressure();
    tb_wd[0] = 32'hCAFEF00D; tb_wd[1] = 32'h0BADC0DE;
    tb_ws[0] = 4'hF; tb_ws[1] = 4'hF; tb_wu[0] = 1'b0; tb_wu[1] = 1'b1;
    wr_burst(8'h20, 1, 1, 5);
    rstall[1] = 2;
    rd_burst(8'h20, 1);
    rstall[1] = 0;
  endtask

  task automatic test_errors();
    tb_wd[0] = 32'h5A5A5A5A; tb_wd[1] = 32'hA5A5A5A5;
    tb_ws[0] = 4'hF; tb_ws[1] = 4'hF; tb_wu[0] = 1'b1; tb_wu[1] = 1'b0;
    wr_burst(8'h7C, 1, 1, 0);
    rd_burst(8'h7C, 1);
    tb_wd[0] = 32'h01020304; tb_wd[1] = 32'h05060708;
    wr_burst(8'h40, 1, 0, 0);
    rd_burst(8'h40, 1);
  endtask

  task automatic test_concurrent();
    logic [31:0] old_d[8];
    logic [31:0] new_d[8];
    for (int k = 0; k < 8; k++) begin
      old_d[k] = model_mem[k];
      new_d[k] = 32'hC0DE0000 + 32'(k);
      tb_wd[k] = new_d[k]; tb_ws[k] = 4'hF; tb_wu[k] = 1'(k + 1);
    end
    wstall_cyc = 0;
    fork
      wr_burst(8'h00, 7, 7, 0);
      begin
        int n;
        araddr = 8'h00; arlen = 8'd7; arvalid = 1;
        n = 0;
        while (arready !== 1'b1 && n < 50) begin cyc(); n++; end
        total++;
        if (n >= 50) $display("FAIL conc_ar_timeout arready=%b need 1", arready); else passed++;
        cyc();
        arvalid = 0;
        rready = 1;
        for (int k = 0; k < 8; k++) begin
          total++;
          if (rvalid !== 1'b1 || (rdata !== old_d[k] && rdata !== new_d[k]) || rlast !== (k == 7))
            $display("FAIL conc_beat %0d got v=%b data=%h last=%b need 1 %h|%h last=%0d",
                     k, rvalid, rdata, rlast, old_d[k], new_d[k], (k == 7));
          else passed++;
          cyc();
        end
        rready = 0;
      end
    join
    total++;
    if (wstall_cyc !== 0) $display("FAIL conc_w_rate stall cycles=%0d need 0", wstall_cyc); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    int n;
    awaddr = 8'h00; awlen = 8'd3; awvalid = 1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin cyc(); n++; end
    cyc();
    awvalid = 0;
    wstrb = 4'hF; wuser = 1'b1; wlast = 0;
    for (int k = 0; k < 2; k++) begin
      wdata = 32'h77770000 + 32'(k); wvalid = 1;
      total++;
      if (wready !== 1'b1) $display("FAIL mid_wready beat %0d got %b need 1", k, wready); else passed++;
      cyc();
    end
    wdata = 32'h77770002;
    aresetn = 0;
    cyc();
    total++;
    if ({awready, wready, bvalid, bresp, buser, arready, rvalid, rdata, rresp, rlast, ruser} !== '0)
      $display("FAIL mid_reset_outputs got aw/w/b/ar/r=%b%b%b%b%b need all 0", awready, wready, bvalid, arready, rvalid);
    else passed++;
    aresetn = 1; wvalid = 0;
    cyc();
    total++;
    if ({awready, arready, wready, bvalid} !== 4'b1100)
      $display("FAIL mid_release got aw/ar/w/b=%b%b%b%b need 1100", awready, arready, wready, bvalid);
    else passed++;
    for (int i = 0; i < DEPTH; i++) begin model_mem[i] = '0; model_user[i] = '0; end
    rd_burst(8'h00, DEPTH - 1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin model_mem[i] = '0; model_user[i] = '0; end
    for (int i = 0; i < 16; i++) rstall[i] = 0;
    test_reset();
    test_single();
    test_strobe_burst();
    test_backpressure();
    test_errors();
    test_concurrent();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- AXI burst slave backed by on-chip word memory; the downstream consumer of the AXI bus interface's slave modport, sitting below any AXI master in the testbench or SoC.
- Independent write path (AW/W/B) and read path (AR/R); one outstanding burst per path; INCR bursts only.
- Stores a user sideband per word: writes capture wuser and reads return it on ruser.

Parameters:
- ADDR_WIDTH, 8: byte address width.
- DATA_WIDTH, 32: data width; multiple of 8; STRB = DATA_WIDTH/8.
- USER_WIDTH, 1: width of wuser, buser and ruser.
- MEM_DEPTH, 32: number of words. MEM_DEPTH*STRB must not exceed 2^ADDR_WIDTH.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- awaddr  in  ADDR_WIDTH  write burst start byte address.
- awlen  in  8  write beats minus 1.
- awvalid  in  1 / awready  out  1  write address handshake.
- wdata  in  DATA_WIDTH / wstrb  in  STRB / wlast  in  1 / wuser  in  USER_WIDTH  write beat.
- wvalid  in  1 / wready  out  1  write data handshake.
- bresp  out  2 / buser  out  USER_WIDTH / bvalid  out  1 / bready  in  1  write response.
- araddr  in  ADDR_WIDTH / arlen  in  8 / arvalid  in  1 / arready  out  1  read address.
- rdata  out  DATA_WIDTH / rresp  out  2 / rlast  out  1 / ruser  out  USER_WIDTH / rvalid  out  1 / rready  in  1  read data.

Behaviour:
- Reset: synchronous; takes effect on the first rising aclk edge with aresetn=0.
  - All outputs are 0 while in reset, including awready and arready.
  - Both FSMs go to IDLE; any in-flight bursts are abandoned with no response.
  - Memory data and user contents clear to 0.
  - First cycle after aresetn=1: awready=1 and arready=1. All outputs are registered.
- Addressing:
  - Word index = awaddr/araddr >> log2(STRB); low address bits are ignored.
  - Index increments by 1 per beat, computed 9 bits wide so it never wraps.
  - A beat with index >= MEM_DEPTH is out of range.
- Write FSM, three states:
  - W_IDLE: awready=1. On awvalid&awready, latch address and length; next state W_DATA, awready=0, wready=1 next cycle.
  - W_DATA: wready=1. On each wvalid&wready:
    - In-range beat: write the byte lanes whose wstrb bit is 1 (lanes with wstrb=0 unchanged); store wuser unconditionally.
    - Out-of-range beat: dropped; sets the error flag.
    - A wlast value that disagrees with (beat==awlen) also sets the error flag.
    - The burst ends on beat count awlen+1, regardless of wlast.
    - After the last beat: wready=0, next state W_RESP.
  - W_RESP: bvalid=1 from the cycle after the last W handshake.
    - bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00.
    - buser = wuser of the last beat.
    - Outputs are held stable until bready. On handshake: bvalid=0, error flag cleared, W_IDLE, awready=1 next cycle.
- Read FSM, two states:
  - R_IDLE: arready=1. On handshake, latch address and length; next cycle rvalid=1 with beat 0 on rdata/ruser/rresp/rlast.
  - R_DATA: outputs are held while rvalid&!rready.
    - On a handshake of a non-last beat, beat k+1 is presented the next cycle with rvalid held at 1; full throughput is 1 beat/cycle.
    - rlast=1 only on beat arlen.
    - Out-of-range beat: rdata=0, ruser=0, rresp=2'b10. Otherwise rresp=2'b00.
    - On the rlast handshake: rvalid=0, R_IDLE, arready=1 next cycle.
- Concurrency:
  - The write and read paths run fully independently.
  - A read sampling a word in the same cycle that word is written returns the old contents (read-before-write).
- Valid is never deasserted without a handshake. No combinational path from any input to any output.

Test Plan:
- Single write then read: AW addr 0x08 len 0; W 0xDEADBEEF, strb 0xF, wuser 1 -> bresp 0, buser 1. AR 0x08 len 0 -> rdata 0xDEADBEEF, ruser 1, rlast 1, rresp 0; rvalid rises exactly one cycle after AR handshake.
- Burst with strobes: AW 0x10 len 3, data 0x11111111..0x44444444; then a single write to 0x14 of 0xAABBCCDD with strb 0x3 -> read burst 0x10 len 3 returns 0x11111111, 0x2222CCDD, 0x33333333, 0x44444444; rlast on beat 3 only.
- Backpressure: rready toggled 1,0,0,1 and bready held 0 for 5 cycles -> rdata/bresp stable while stalled, no beat lost or duplicated, awready stays 0 until B handshake.
- Error cases:
  - AW 0x7C len 1 (MEM_DEPTH 32) -> bresp 2'b10 and word 31 written.
  - Read 0x7C len 1 -> beat 0 rresp 0, beat 1 rresp 2'b10 with rdata 0.
  - Write len 1 with wlast on beat 0 -> bresp 2'b10, and both beats are still consumed.
- Concurrent: read burst of 8 overlapping a simultaneous write burst of 8 to the same addresses -> each beat shows either old or new data per the read-before-write rule; both complete at 1 beat/cycle.
- Reset mid-burst: aresetn=0 for 1 cycle during W_DATA beat 2 -> next cycle all outputs 0; after release, awready=1 and arready=1, and every word reads back 0.
